mult_par_pipe: RTL and testbench



---
 rtl/mult_par_pkg.sv | 24 ++
 rtl/mult_par_chk.sv | 17 +
 rtl/mult_par_pipe.sv | 151 +++++++++++++++
 tb/tb_mult_par_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_par_pkg.sv
// Shared types and parity helpers for the parity-checked signed multiplier.
package mult_par_pkg;

    // Widest operand/result the parity helpers accept; narrower data is zero-extended.
    localparam int unsigned PAR_MAX_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Parity bit to transmit alongside data: even -> ^data, odd -> ~^data.
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] data, input logic odd);
        parity_bit = (^data) ^ odd;
    endfunction

    // Data plus its parity bit is valid when their combined XOR equals the odd flag.
    function automatic logic parity_ok(input logic [PAR_MAX_W-1:0] data, input logic par,
                                       input logic odd);
        parity_ok = (((^data) ^ par) == odd);
    endfunction

endpackage

// File: rtl/mult_par_chk.sv
// Combinational operand parity checker; one instance per operand.
module mult_par_chk
    import mult_par_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic [WIDTH-1:0] data,
    input  logic             parity,
    output logic             valid_c
);

    always_comb begin
        valid_c = parity_ok(PAR_MAX_W'(data), parity, PARITY_ODD);
    end

endmodule

// File: rtl/mult_par_pipe.sv
// Parametrised signed multiplier with req/ack capture, operand parity checking,
// fixed compute latency and a registered, held result.
module mult_par_pipe
    import mult_par_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LATENCY    = 3,
    parameter bit          PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     arg_a,
    input  logic                 arg_a_parity,
    input  logic [WIDTH-1:0]     arg_b,
    input  logic                 arg_b_parity,
    input  logic                 req,
    output logic                 ack,
    output logic [2*WIDTH-1:0]   result,
    output logic                 result_parity,
    output logic                 result_rdy,
    output logic                 arg_parity_error
);

    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               a_par_q, a_par_d;
    logic               b_par_q, b_par_d;
    logic               ack_q, ack_d;
    logic               rdy_q, rdy_d;
    logic               err_q, err_d;
    logic [PW-1:0]      result_q, result_d;
    logic               res_par_q, res_par_d;

    logic               a_ok_c;
    logic               b_ok_c;
    logic signed [PW-1:0] product_c;

    // Parity is judged on the captured operands, not the live inputs.
    mult_par_chk #(
        .WIDTH      (WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) u_chk_a (
        .data    (a_q),
        .parity  (a_par_q),
        .valid_c (a_ok_c)
    );

    mult_par_chk #(
        .WIDTH      (WIDTH),
        .PARITY_ODD (PARITY_ODD)
    ) u_chk_b (
        .data    (b_q),
        .parity  (b_par_q),
        .valid_c (b_ok_c)
    );

    // Operands are sign-extended before multiplying so the full product fits.
    always_comb begin
        product_c = PW'($signed(a_q)) * PW'($signed(b_q));
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        a_par_d   = a_par_q;
        b_par_d   = b_par_q;
        ack_d     = 1'b0;
        rdy_d     = 1'b0;
        err_d     = err_q;
        result_d  = result_q;
        res_par_d = res_par_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    a_d     = arg_a;
                    b_d     = arg_b;
                    a_par_d = arg_a_parity;
                    b_par_d = arg_b_parity;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    ack_d   = 1'b1;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    rdy_d   = 1'b1;
                    if (a_ok_c && b_ok_c) begin
                        result_d = product_c;
                        err_d    = 1'b0;
                    end else begin
                        result_d = '0;
                        err_d    = 1'b1;
                    end
                    res_par_d = parity_bit(PAR_MAX_W'(result_d), PARITY_ODD);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            a_par_q   <= 1'b0;
            b_par_q   <= 1'b0;
            ack_q     <= 1'b0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            res_par_q <= PARITY_ODD;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            a_par_q   <= a_par_d;
            b_par_q   <= b_par_d;
            ack_q     <= ack_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            result_q  <= result_d;
            res_par_q <= res_par_d;
        end
    end

    assign ack              = ack_q;
    assign result_rdy       = rdy_q;
    assign arg_parity_error = err_q;
    assign result           = result_q;
    assign result_parity    = res_par_q;

endmodule

// File: tb/tb_mult_par_pipe.sv
// Directed bench for mult_par_pipe: default, odd-parity and 8-bit/latency-1 instances.
module tb_mult_par_pipe;
    import mult_par_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    // Default instance: WIDTH=16, LATENCY=3, even parity.
    logic [15:0] m_a = '0, m_b = '0;
    logic        m_pa = 1'b0, m_pb = 1'b0, m_req = 1'b0;
    logic        m_ack, m_rp, m_rdy, m_err;
    logic [31:0] m_res;

    mult_par_pipe #(.WIDTH(16), .LATENCY(3), .PARITY_ODD(1'b0)) u_dut (
        .clk(clk), .rst(rst), .arg_a(m_a), .arg_a_parity(m_pa), .arg_b(m_b),
        .arg_b_parity(m_pb), .req(m_req), .ack(m_ack), .result(m_res),
        .result_parity(m_rp), .result_rdy(m_rdy), .arg_parity_error(m_err));

    // Odd-parity instance.
    logic [15:0] o_a = '0, o_b = '0;
    logic        o_pa = 1'b0, o_pb = 1'b0, o_req = 1'b0;
    logic        o_ack, o_rp, o_rdy, o_err;
    logic [31:0] o_res;

    mult_par_pipe #(.WIDTH(16), .LATENCY(3), .PARITY_ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .arg_a(o_a), .arg_a_parity(o_pa), .arg_b(o_b),
        .arg_b_parity(o_pb), .req(o_req), .ack(o_ack), .result(o_res),
        .result_parity(o_rp), .result_rdy(o_rdy), .arg_parity_error(o_err));

    // Narrow, minimum-latency instance.
    logic [7:0]  w_a = '0, w_b = '0;
    logic        w_pa = 1'b0, w_pb = 1'b0, w_req = 1'b0;
    logic        w_ack, w_rp, w_rdy, w_err;
    logic [15:0] w_res;

    mult_par_pipe #(.WIDTH(8), .LATENCY(1), .PARITY_ODD(1'b0)) u_w8 (
        .clk(clk), .rst(rst), .arg_a(w_a), .arg_a_parity(w_pa), .arg_b(w_b),
        .arg_b_parity(w_pb), .req(w_req), .ack(w_ack), .result(w_res),
        .result_parity(w_rp), .result_rdy(w_rdy), .arg_parity_error(w_err));

    // Drivers: raise req before edge N, then record in which cycle (N+c) ack/rdy appear.
    task automatic run_main(input logic [15:0] a, input logic pa, input logic [15:0] b,
                            input logic pb, output int ack_at, output int rdy_at,
                            output int ack_n, output int rdy_n);
        ack_at = -1; rdy_at = -1; ack_n = 0; rdy_n = 0;
        m_a = a; m_pa = pa; m_b = b; m_pb = pb; m_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (m_ack) begin ack_n++; if (ack_at < 0) ack_at = c; m_req = 1'b0; end
            if (m_rdy) begin rdy_n++; if (rdy_at < 0) rdy_at = c; end
        end
        m_req = 1'b0;
    endtask

    task automatic run_odd(input logic [15:0] a, input logic pa, input logic [15:0] b,
                           input logic pb, output int rdy_at);
        rdy_at = -1;
        o_a = a; o_pa = pa; o_b = b; o_pb = pb; o_req = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (o_ack) o_req = 1'b0;
            if (o_rdy && rdy_at < 0) rdy_at = c;
        end
        o_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (m_ack !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", m_ack); end
        checks++; if (m_rdy !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", m_rdy); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", m_err); end
        checks++; if (m_res !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", m_res); end
        checks++; if (m_rp !== 1'b0) begin failures++; $display("FAIL reset_rpar got=%b exp=0", m_rp); end
        checks++; if (o_rp !== 1'b1) begin failures++; $display("FAIL reset_odd_rpar got=%b exp=1", o_rp); end
        checks++; if (u_dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", u_dut.state_q); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int ack_at, rdy_at, ack_n, rdy_n;
        run_main(16'd3, 1'b0, 16'hFFFB, 1'b1, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (ack_at !== 1) begin failures++; $display("FAIL basic_ack_cycle got=%0d exp=1", ack_at); end
        checks++; if (ack_n !== 1) begin failures++; $display("FAIL basic_ack_width got=%0d exp=1", ack_n); end
        checks++; if (rdy_at !== 4) begin failures++; $display("FAIL basic_rdy_cycle got=%0d exp=4", rdy_at); end
        checks++; if (rdy_n !== 1) begin failures++; $display("FAIL basic_rdy_width got=%0d exp=1", rdy_n); end
        checks++; if (m_res !== 32'hFFFF_FFF1) begin failures++; $display("FAIL basic_result got=%h exp=fffffff1", m_res); end
        checks++; if (m_rp !== 1'b1) begin failures++; $display("FAIL basic_rpar got=%b exp=1", m_rp); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", m_err); end
        run_main(16'h0100, 1'b1, 16'd3, 1'b0, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (m_res !== 32'h0000_0300) begin failures++; $display("FAIL basic2_result got=%h exp=00000300", m_res); end
        checks++; if (m_rp !== 1'b0) begin failures++; $display("FAIL basic2_rpar got=%b exp=0", m_rp); end
    endtask

    task automatic test_corner();
        int ack_at, rdy_at, ack_n, rdy_n;
        run_main(16'h8000, 1'b1, 16'h8000, 1'b1, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (m_res !== 32'h4000_0000) begin failures++; $display("FAIL corner_minsq got=%h exp=40000000", m_res); end
        checks++; if (m_rp !== 1'b1) begin failures++; $display("FAIL corner_minsq_rpar got=%b exp=1", m_rp); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL corner_minsq_err got=%b exp=0", m_err); end
        run_main(16'h7FFF, 1'b1, 16'h8000, 1'b1, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (m_res !== 32'hC000_8000) begin failures++; $display("FAIL corner_maxmin got=%h exp=c0008000", m_res); end
        checks++; if (m_rp !== 1'b1) begin failures++; $display("FAIL corner_maxmin_rpar got=%b exp=1", m_rp); end
    endtask

    task automatic test_parity_error();
        int ack_at, rdy_at, ack_n, rdy_n;
        run_main(16'd7, 1'b0, 16'd2, 1'b1, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (rdy_at !== 4) begin failures++; $display("FAIL perr_rdy_cycle got=%0d exp=4", rdy_at); end
        checks++; if (m_res !== 32'h0) begin failures++; $display("FAIL perr_result got=%h exp=0", m_res); end
        checks++; if (m_rp !== 1'b0) begin failures++; $display("FAIL perr_rpar got=%b exp=0", m_rp); end
        checks++; if (m_err !== 1'b1) begin failures++; $display("FAIL perr_err got=%b exp=1", m_err); end
        run_main(16'hFFFF, 1'b0, 16'hFFFF, 1'b0, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL perr_clear got=%b exp=0", m_err); end
        checks++; if (m_res !== 32'h1) begin failures++; $display("FAIL perr_next_result got=%h exp=1", m_res); end
        checks++; if (m_rp !== 1'b1) begin failures++; $display("FAIL perr_next_rpar got=%b exp=1", m_rp); end
    endtask

    task automatic test_reset_mid();
        int ack_at, rdy_at, ack_n, rdy_n, late_rdy;
        m_a = 16'd3; m_pa = 1'b0; m_b = 16'd3; m_pb = 1'b0; m_req = 1'b1;
        @(posedge clk); #1;          // edge N sampled req
        m_req = 1'b0;
        @(posedge clk); #1;          // cycle N+2
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (m_res !== 32'h0) begin failures++; $display("FAIL rstmid_result got=%h exp=0", m_res); end
        checks++; if (m_rp !== 1'b0) begin failures++; $display("FAIL rstmid_rpar got=%b exp=0", m_rp); end
        checks++; if (m_err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", m_err); end
        checks++; if (m_ack !== 1'b0) begin failures++; $display("FAIL rstmid_ack got=%b exp=0", m_ack); end
        checks++; if (u_dut.state_q !== IDLE) begin failures++; $display("FAIL rstmid_state got=%0d exp=0", u_dut.state_q); end
        late_rdy = 0;
        for (int c = 0; c < 6; c++) begin
            if (m_rdy) late_rdy++;
            @(posedge clk); #1;
        end
        checks++; if (late_rdy !== 0) begin failures++; $display("FAIL rstmid_no_rdy got=%0d exp=0", late_rdy); end
        run_main(16'hFFFE, 1'b1, 16'd3, 1'b0, ack_at, rdy_at, ack_n, rdy_n);
        checks++; if (ack_at !== 1) begin failures++; $display("FAIL rstmid_next_ack got=%0d exp=1", ack_at); end
        checks++; if (rdy_at !== 4) begin failures++; $display("FAIL rstmid_next_rdy got=%0d exp=4", rdy_at); end
        checks++; if (m_res !== 32'hFFFF_FFFA) begin failures++; $display("FAIL rstmid_next_result got=%h exp=fffffffa", m_res); end
        checks++; if (m_rp !== 1'b0) begin failures++; $display("FAIL rstmid_next_rpar got=%b exp=0", m_rp); end
    endtask

    task automatic test_back_to_back();
        int          acks[$];
        int          rdys[$];
        logic [31:0] exp_res [3] = '{32'h0000_0006, 32'h0000_0023, 32'hFFFF_FFF8};
        logic        exp_rp  [3] = '{1'b0, 1'b1, 1'b1};
        int          exp_ack [3] = '{1, 6, 11};
        int          exp_rdy [3] = '{4, 9, 14};
        m_a = 16'd2; m_pa = 1'b1; m_b = 16'd3; m_pb = 1'b0; m_req = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(posedge clk); #1;
            if (m_rdy) begin
                if (rdys.size() < 3) begin
                    checks++;
                    if (m_res !== exp_res[rdys.size()]) begin
                        failures++;
                        $display("FAIL b2b_result%0d got=%h exp=%h", rdys.size(), m_res, exp_res[rdys.size()]);
                    end
                    checks++;
                    if (m_rp !== exp_rp[rdys.size()]) begin
                        failures++;
                        $display("FAIL b2b_rpar%0d got=%b exp=%b", rdys.size(), m_rp, exp_rp[rdys.size()]);
                    end
                end
                rdys.push_back(c);
            end
            if (m_ack) begin
                acks.push_back(c);
                // Change operands mid-calculation; only the next capture may see them.
                case (acks.size())
                    1: begin m_a = 16'd5;    m_pa = 1'b0; m_b = 16'd7; m_pb = 1'b1; end
                    2: begin m_a = 16'hFFFE; m_pa = 1'b1; m_b = 16'd4; m_pb = 1'b1; end
                    default: begin m_a = 16'h1234; m_pa = 1'b1; m_b = 16'h0F0F; m_pb = 1'b0; m_req = 1'b0; end
                endcase
            end
        end
        m_req = 1'b0;
        checks++; if (acks.size() !== 3) begin failures++; $display("FAIL b2b_ack_count got=%0d exp=3", acks.size()); end
        checks++; if (rdys.size() !== 3) begin failures++; $display("FAIL b2b_rdy_count got=%0d exp=3", rdys.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < acks.size()) begin
                checks++;
                if (acks[k] !== exp_ack[k]) begin failures++; $display("FAIL b2b_ack_cycle%0d got=%0d exp=%0d", k, acks[k], exp_ack[k]); end
            end
            if (k < rdys.size()) begin
                checks++;
                if (rdys[k] !== exp_rdy[k]) begin failures++; $display("FAIL b2b_rdy_cycle%0d got=%0d exp=%0d", k, rdys[k], exp_rdy[k]); end
            end
        end
    endtask

    task automatic test_odd();
        int rdy_at;
        run_odd(16'd1, 1'b0, 16'd1, 1'b0, rdy_at);
        checks++; if (rdy_at !== 4) begin failures++; $display("FAIL odd_rdy_cycle got=%0d exp=4", rdy_at); end
        checks++; if (o_res !== 32'h1) begin failures++; $display("FAIL odd_result got=%h exp=1", o_res); end
        checks++; if (o_rp !== 1'b0) begin failures++; $display("FAIL odd_rpar got=%b exp=0", o_rp); end
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL odd_err got=%b exp=0", o_err); end
        run_odd(16'd1, 1'b1, 16'd1, 1'b0, rdy_at);
        checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL odd_perr_err got=%b exp=1", o_err); end
        checks++; if (o_res !== 32'h0) begin failures++; $display("FAIL odd_perr_result got=%h exp=0", o_res); end
        checks++; if (o_rp !== 1'b1) begin failures++; $display("FAIL odd_perr_rpar got=%b exp=1", o_rp); end
    endtask

    task automatic test_width8();
        int ack_at = -1;
        int rdy_at = -1;
        w_a = 8'h80; w_pa = 1'b1; w_b = 8'h80; w_pb = 1'b1; w_req = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (w_ack) begin if (ack_at < 0) ack_at = c; w_req = 1'b0; end
            if (w_rdy && rdy_at < 0) rdy_at = c;
        end
        w_req = 1'b0;
        checks++; if (ack_at !== 1) begin failures++; $display("FAIL w8_ack_cycle got=%0d exp=1", ack_at); end
        checks++; if (rdy_at !== 2) begin failures++; $display("FAIL w8_rdy_cycle got=%0d exp=2", rdy_at); end
        checks++; if (w_res !== 16'h4000) begin failures++; $display("FAIL w8_result got=%h exp=4000", w_res); end
        checks++; if (w_rp !== 1'b1) begin failures++; $display("FAIL w8_rpar got=%b exp=1", w_rp); end
        checks++; if (w_err !== 1'b0) begin failures++; $display("FAIL w8_err got=%b exp=0", w_err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corner();
        test_parity_error();
        test_reset_mid();
        test_back_to_back();
        test_odd();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
